// File: rtl/bcd_counter_chain.sv
// Cascaded up/down modulo-MODULUS digit counter with load, optional saturation, tick/wrap/load_err flags.
// Latency: one falling clk edge from en/load to count and flags; no backpressure, input accepted every edge.
module bcd_counter_chain #(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  load_err
);

    localparam logic [3:0] DIGIT_MAX = 4'(MODULUS - 1);
    localparam logic [4:0] DIGIT_MOD = 5'(MODULUS);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;
    logic                carry;

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        tick_d     = 1'b1;
        carry      = 1'b0;

        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ({1'b0, load_val[4*k +: 4]} >= DIGIT_MOD) begin
                    count_d[4*k +: 4] = 4'd0;
                    load_err_d        = 1'b1;
                end else begin
                    count_d[4*k +: 4] = load_val[4*k +: 4];
                end
            end
        end else if (en) begin
            // carry doubles as borrow; surviving past the top digit means we were at the terminal value
            carry = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (carry) begin
                    if (up) begin
                        if (count_q[4*k +: 4] == DIGIT_MAX) begin
                            count_d[4*k +: 4] = 4'd0;
                        end else begin
                            count_d[4*k +: 4] = 4'(count_q[4*k +: 4] + 4'd1);
                            carry             = 1'b0;
                        end
                    end else begin
                        if (count_q[4*k +: 4] == 4'd0) begin
                            count_d[4*k +: 4] = DIGIT_MAX;
                        end else begin
                            count_d[4*k +: 4] = 4'(count_q[4*k +: 4] - 4'd1);
                            carry             = 1'b0;
                        end
                    end
                end
            end
            if (carry) begin
                if (SATURATE != 0) begin
                    count_d = count_q;
                end else begin
                    wrap_d = 1'b1;
                end
            end
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (count_d[4*k +: 4] != (up ? DIGIT_MAX : 4'd0)) begin
                tick_d = 1'b0;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain: decimal wrap, saturating and hex instances share one stimulus bus.
module tb_bcd_counter_chain;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] count;
    logic       tick, wrap, load_err;
    logic [7:0] s_count;
    logic       s_tick, s_wrap, s_load_err;
    logic [3:0] h_count;
    logic       h_tick, h_wrap, h_load_err;

    int vectors = 0;
    int errors  = 0;

    bcd_counter_chain #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tick(tick), .wrap(wrap), .load_err(load_err)
    );

    bcd_counter_chain #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(s_count), .tick(s_tick), .wrap(s_wrap), .load_err(s_load_err)
    );

    bcd_counter_chain #(.DIGITS(1), .MODULUS(16), .SATURATE(0)) u_hex (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .count(h_count), .tick(h_tick), .wrap(h_wrap), .load_err(h_load_err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Advance past the next active (falling) edge and settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        #2;
        vectors++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", count); end
        vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        vectors++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        vectors++; if (h_count !== 4'h0) begin errors++; $display("FAIL reset_hex_count: got %h want 0", h_count); end
        step();
        vectors++; if (count !== 8'h00) begin errors++; $display("FAIL reset_held_count: got %h want 00", count); end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_c;
        en = 1'b1; up = 1'b1;
        #1 reset = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            exp_c = to_bcd(i % 100);
            vectors++; if (count !== exp_c) begin errors++; $display("FAIL up_count[%0d]: got %h want %h", i, count, exp_c); end
            vectors++; if (tick !== (exp_c == 8'h99)) begin errors++; $display("FAIL up_tick[%0d]: got %b want %b", i, tick, exp_c == 8'h99); end
            vectors++; if (wrap !== (i == 100)) begin errors++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, i == 100); end
        end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_val = 8'h01; en = 1'b0; up = 1'b1;
        step();
        vectors++; if (count !== 8'h01) begin errors++; $display("FAIL down_load: got %h want 01", count); end
        load = 1'b0; up = 1'b0; en = 1'b1;
        step();
        vectors++; if (count !== 8'h00) begin errors++; $display("FAIL down_zero_count: got %h want 00", count); end
        vectors++; if (tick !== 1'b1) begin errors++; $display("FAIL down_zero_tick: got %b want 1", tick); end
        vectors++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_zero_wrap: got %b want 0", wrap); end
        step();
        vectors++; if (count !== 8'h99) begin errors++; $display("FAIL down_wrap_count: got %h want 99", count); end
        vectors++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_wrap: got %b want 1", wrap); end
        vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL down_wrap_tick: got %b want 0", tick); end
        step();
        vectors++; if (count !== 8'h98) begin errors++; $display("FAIL down_after_wrap: got %h want 98", count); end
        vectors++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_one_cycle: got %b want 0", wrap); end
    endtask

    task automatic test_illegal_load();
        load = 1'b1; load_val = 8'hA7; en = 1'b1; up = 1'b1;
        step();
        vectors++; if (count !== 8'h07) begin errors++; $display("FAIL illegal_count: got %h want 07", count); end
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", load_err); end
        vectors++; if (wrap !== 1'b0) begin errors++; $display("FAIL illegal_wrap: got %b want 0", wrap); end
        load = 1'b0; en = 1'b0;
        step();
        vectors++; if (count !== 8'h07) begin errors++; $display("FAIL illegal_hold: got %h want 07", count); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %b want 0", load_err); end
        load = 1'b1; load_val = 8'h5C;
        step();
        vectors++; if (count !== 8'h50) begin errors++; $display("FAIL illegal_low_digit: got %h want 50", count); end
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL illegal_low_err: got %b want 1", load_err); end
        load = 1'b0;
    endtask

    task automatic test_load_terminal();
        load = 1'b1; load_val = 8'h99; en = 1'b0; up = 1'b1;
        step();
        vectors++; if (tick !== 1'b1) begin errors++; $display("FAIL load_term_tick: got %b want 1", tick); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_term_err: got %b want 0", load_err); end
        load = 1'b0; up = 1'b0;
        step();
        vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL dir_change_tick: got %b want 0", tick); end
        vectors++; if (count !== 8'h99) begin errors++; $display("FAIL dir_change_count: got %h want 99", count); end
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 8'h98; en = 1'b0; up = 1'b1;
        step();
        vectors++; if (s_count !== 8'h98) begin errors++; $display("FAIL sat_load: got %h want 98", s_count); end
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (s_count !== 8'h99) begin errors++; $display("FAIL sat_count[%0d]: got %h want 99", i, s_count); end
            vectors++; if (s_tick !== 1'b1) begin errors++; $display("FAIL sat_tick[%0d]: got %b want 1", i, s_tick); end
            vectors++; if (s_wrap !== 1'b0) begin errors++; $display("FAIL sat_wrap[%0d]: got %b want 0", i, s_wrap); end
        end
        vectors++; if (count !== 8'h01) begin errors++; $display("FAIL sat_ref_wrapped: got %h want 01", count); end
        load = 1'b1; load_val = 8'h00; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        vectors++; if (s_count !== 8'h00) begin errors++; $display("FAIL sat_down_hold: got %h want 00", s_count); end
        vectors++; if (s_wrap !== 1'b0) begin errors++; $display("FAIL sat_down_wrap: got %b want 0", s_wrap); end
        vectors++; if (s_tick !== 1'b1) begin errors++; $display("FAIL sat_down_tick: got %b want 1", s_tick); end
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_val = 8'h45; en = 1'b0; up = 1'b1;
        step();
        vectors++; if (count !== 8'h45) begin errors++; $display("FAIL mid_load: got %h want 45", count); end
        load = 1'b0; en = 1'b1;
        #2 reset = 1'b0;
        #1;
        vectors++; if (count !== 8'h00) begin errors++; $display("FAIL mid_reset_count: got %h want 00", count); end
        vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_reset_tick: got %b want 0", tick); end
        vectors++; if (s_count !== 8'h00) begin errors++; $display("FAIL mid_reset_sat: got %h want 00", s_count); end
        en = 1'b0; up = 1'b0;
        #1 reset = 1'b1;
        step();
        vectors++; if (tick !== 1'b1) begin errors++; $display("FAIL mid_release_tick: got %b want 1", tick); end
        vectors++; if (count !== 8'h00) begin errors++; $display("FAIL mid_release_count: got %h want 00", count); end
    endtask

    task automatic test_hex();
        int         wraps;
        logic [3:0] exp_h;
        wraps = 0;
        load = 1'b1; load_val = 8'h00; en = 1'b0; up = 1'b1;
        step();
        vectors++; if (h_count !== 4'h0) begin errors++; $display("FAIL hex_start: got %h want 0", h_count); end
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_h = 4'(i % 16);
            if (h_wrap === 1'b1) wraps++;
            vectors++; if (h_count !== exp_h) begin errors++; $display("FAIL hex_count[%0d]: got %h want %h", i, h_count, exp_h); end
            vectors++; if (h_tick !== (exp_h == 4'hF)) begin errors++; $display("FAIL hex_tick[%0d]: got %b want %b", i, h_tick, exp_h == 4'hF); end
        end
        vectors++; if (wraps != 1) begin errors++; $display("FAIL hex_wrap_pulses: got %0d want 1", wraps); end
        vectors++; if (h_wrap !== 1'b1) begin errors++; $display("FAIL hex_wrap_at_zero: got %b want 1", h_wrap); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_wrap();
        test_illegal_load();
        test_load_terminal();
        test_saturate();
        test_mid_reset();
        test_hex();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised cascaded modulo-N counter for the lab counter/timer datapath. It counts up or down across `DIGITS` digits, each 4 bits wide and modulo `MODULUS`. It supports synchronous load, optional saturation, a registered terminal-count `tick`, and a one-cycle `wrap` pulse. It generalises the single-digit mod-10 counter and feeds display drivers and downstream dividers.

## Interface
- `DIGITS`, default 2: number of cascaded digits, legal range 1..8.
- `MODULUS`, default 10: per-digit modulus, legal range 2..16.
- `SATURATE`, default 0: behaviour at the end of the range.
  - 0: wrap around.
  - 1: hold at the terminal value.
- `clk` input, 1 bit: all state updates on the falling edge.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `en` input, 1 bit: count enable.
- `up` input, 1 bit: count direction, 1 = up, 0 = down.
- `load` input, 1 bit: synchronous load strobe.
- `load_val` input, `4*DIGITS` bits: value to load, digit 0 in bits [3:0].
- `count` output, `4*DIGITS` bits: current value, digit 0 least significant, each digit in 0..MODULUS-1.
- `tick` output, 1 bit: registered; high while `count` equals the terminal value for the current `up`.
- `wrap` output, 1 bit: registered one-cycle pulse marking a wrap-around.
- `load_err` output, 1 bit: registered one-cycle pulse on a load containing an illegal digit.

## Operation
- Reset (`reset`=0, asynchronous): `count`=0, `tick`=0, `wrap`=0, `load_err`=0. All outputs hold these values while reset is low.
- Terminal value:
  - Up: every digit equals MODULUS-1.
  - Down: every digit equals 0.
- Priority on each falling edge: load, then en, then hold.
- Load (`load`=1, regardless of `en`):
  - `count` takes `load_val` digit-wise.
  - Any digit ≥ MODULUS is stored as 0, and `load_err`=1 for that cycle.
  - `wrap`=0.
- Count up (`en`=1, `up`=1):
  - Digit 0 increments.
  - Digit k increments only if every lower digit equals MODULUS-1. A digit at MODULUS-1 that increments becomes 0.
  - From the terminal value with SATURATE=0: `count` becomes all zeros and `wrap`=1.
  - From the terminal value with SATURATE=1: `count` holds and `wrap`=0.
- Count down (`en`=1, `up`=0):
  - Digit 0 decrements.
  - Digit k decrements only if every lower digit equals 0. A digit at 0 that decrements becomes MODULUS-1.
  - From all zeros with SATURATE=0: `count` becomes all MODULUS-1 and `wrap`=1.
  - From all zeros with SATURATE=1: `count` holds.
- Hold (`en`=0, `load`=0): `count` is unchanged and `wrap`=0.
- `tick` is computed from the next `count` value and the current `up`, then registered on the same edge as `count`. This keeps `tick` aligned with the value it flags; there is no lag.
- A change of `up` alone, with `en`=0, updates `tick` on the next falling edge.
- Digits are never allowed to hold a value ≥ MODULUS.

## Timing
- All registered outputs change only on the falling edge of `clk`, or asynchronously on `reset` falling.
- Latency: 1 edge from `en`/`load` sampled to the new `count`. `tick`, `wrap` and `load_err` change on that same edge.
- `wrap` and `load_err` are high for exactly one clock period unless the triggering condition repeats on consecutive edges. Example: MODULUS=2, DIGITS=1, counting continuously gives `wrap` high every second cycle.
- `reset` assertion mid-count clears everything immediately, with no wait for a clock edge.
- Release of `reset`: the first falling edge after release is a normal operating edge.
- Simultaneous `load` and `en`: load wins and no count occurs on that edge.
- Simultaneous load of the terminal value: `tick`=1 on the same edge.
- Full wrap period: MODULUS^DIGITS enabled edges.

## Test plan
- **Reset, then count up** (DIGITS=2, MODULUS=10, SATURATE=0, `en`=1, `up`=1, 100 edges):
  - `count` steps 0x00→0x99→0x00.
  - `tick`=1 only while `count`=0x99.
  - `wrap`=1 only in the cycle `count`=0x00 after 0x99.
- **Down wrap:** load 0x01, then `up`=0, `en`=1:
  - `count` goes 0x01→0x00 with `tick`=1 at 0x00.
  - Next edge gives 0x99 with `wrap`=1 and `tick`=0.
- **Illegal load:** `load_val`=0xA7 with MODULUS=10 gives `count`=0x07 and `load_err`=1 for one cycle; `en` asserted on the same edge is ignored.
- **Saturation** (SATURATE=1): load 0x98, count up 3 edges:
  - `count` goes 0x99, 0x99, 0x99.
  - `tick` stays 1 and `wrap` stays 0 throughout.
- **Mid-count reset and direction change:** at `count`=0x45, pull `reset` low between edges:
  - `count`=0x00 and `tick`=0 immediately.
  - After release, with `up`=0 and `en`=0, `tick` goes to 1 on the next edge.
- **Non-decimal modulus** (MODULUS=16, DIGITS=1): 16 enabled up edges return `count` to 0 with a single `wrap` pulse.
